// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one CHUNK-bit slice per clock, stops at first difference.
// Optional macro SIGNED_CMP_EN: operands are two's complement (MSB slice compared signed).
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [WIDTH-1:0]                   a,
   input  logic [WIDTH-1:0]                   b,
   output logic                               busy,
   output logic                               done,
   output logic                               eq,
   output logic                               gt,
   output logic                               lt,
   output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

   // Handshake: start is sampled only in IDLE; busy marks CMP; done pulses one cycle with the result.
   typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_busy, r_done, r_eq, r_gt, r_lt;
   logic [CW-1:0]    r_cycles;

   logic [CHUNK-1:0] w_sign_mask;
   logic [CHUNK-1:0] w_slice_a, w_slice_b;
   logic             w_gt, w_lt, w_last;

   always_comb begin
`ifdef SIGNED_CMP_EN
      // Flipping the sign bit of the MSB slice turns the unsigned compare into a signed one.
      w_sign_mask = (r_cycles == '0) ? (CHUNK'(1) << (CHUNK - 1)) : '0;
`else
      w_sign_mask = '0;
`endif
      w_slice_a = r_a[WIDTH-1 -: CHUNK] ^ w_sign_mask;
      w_slice_b = r_b[WIDTH-1 -: CHUNK] ^ w_sign_mask;
      w_gt      = (w_slice_a > w_slice_b);
      w_lt      = (w_slice_a < w_slice_b);
      w_last    = (r_cycles == LAST_IDX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_cycles <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_eq     <= 1'b0;
                  r_gt     <= 1'b0;
                  r_lt     <= 1'b0;
                  r_cycles <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CMP;
               end
            end
            S_CMP: begin
               r_cycles <= r_cycles + CW'(1);
               if (w_gt || w_lt) begin
                  r_gt    <= w_gt;
                  r_lt    <= w_lt;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_last) begin
                  r_eq    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_a <= r_a << CHUNK;
                  r_b <= r_b << CHUNK;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign eq     = r_eq;
   assign gt     = r_gt;
   assign lt     = r_lt;
   assign cycles = r_cycles;

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per clock, and stops at the first differing slice. It produces registered one-hot equal / greater / less flags behind a start/busy/done handshake. It is the clocked, width-generic successor to the team's 4-bit gate-level comparator, for datapaths too wide to compare in one combinational level.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  high while a comparison is in progress (state CMP).
- done  out  1  single-cycle pulse; result valid from this cycle onward.
- eq  out  1  A == B.
- gt  out  1  A > B.
- lt  out  1  A < B.
- cycles  out  clog2(NCHUNK+1)  number of slices examined in the last comparison.

## Operation
- States: IDLE, CMP, DONE.
- IDLE + start=1:
  - Latch a/b into internal shift registers.
  - Clear eq/gt/lt and cycles to 0.
  - Go to CMP.
- IDLE + start=0: hold state; eq/gt/lt/cycles keep the last result.
- CMP, each edge: compare the top CHUNK bits of the A and B registers, and increment cycles.
  - Slices differ: set gt or lt from that slice, go to DONE.
  - Slices equal and this was slice NCHUNK-1: set eq, go to DONE.
  - Otherwise: shift both registers left by CHUNK, stay in CMP.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- start is ignored in CMP and DONE; no queueing. Changes on a/b after acceptance have no effect.
- eq/gt/lt are all 0 from acceptance until the result edge. After that, exactly one is 1, and the flags hold until the next accepted start.
- Slice compare is an unsigned CHUNK-bit compare, except where Configuration says otherwise.

## Timing
- Start accepted at edge E0. The result is registered at edge Ek, where k = slices examined (1..NCHUNK). done and the flags are visible in the cycle after Ek.
- Latency start→done: k cycles; worst case NCHUNK, equal operands. Next start accepted no earlier than the edge after the done cycle. Minimum spacing between accepted starts is k+2 edges.
- busy is high for cycles E0..Ek; it is low in the done cycle and in IDLE.
- Reset (rst_n low, any time, including mid-CMP):
  - state=IDLE, busy=0, done=0, eq=gt=lt=0, cycles=0.
  - Applied immediately, without waiting for a clock edge.
  - The first edge after rst_n rises may accept start.
- All outputs are driven directly from flops; there is no combinational path from input to output.

## Configuration
- SIGNED_CMP_EN defined: operands are two's complement. The first slice compared (the MSB slice) is compared signed, i.e. with its top bit inverted before the unsigned compare. All other slices remain unsigned.
- SIGNED_CMP_EN undefined: every slice is compared unsigned; operands are unsigned magnitudes.
- The macro has no effect on ports, latency or handshake.

## Test plan
- WIDTH=16, CHUNK=4, a=0x1234, b=0x1234 → done 4 cycles after start edge; eq=1, gt=lt=0, cycles=4.
- a=0x12A4, b=0x12B4 → lt=1, cycles=3, done 3 cycles after start; flags hold 0-lt-0 through 10 idle cycles.
- a=0x9000, b=0x1FFF → without SIGNED_CMP_EN: gt=1, cycles=1; with SIGNED_CMP_EN: lt=1, cycles=1. Also a=0xFFFF, b=0x0000 → unsigned gt, signed lt.
- Start a=0x0001, b=0x0002; pulse start with a=0xFFFF, b=0x0000 during CMP and during the done cycle → both ignored; result lt=1, cycles=4; busy never re-asserts until a new start in IDLE.
- rst_n low 2 cycles into the 4-slice equal compare → busy/done/eq/gt/lt/cycles go to 0 before the next edge; no done pulse. After release, a=0x0000, b=0x0000 → eq=1, cycles=4.
- Back-to-back starts held high continuously with a=0x8000, b=0x7000 → each accepted 3 edges apart (k=1); done pulses once per compare; gt=1 each time (unsigned).
